// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opsel codes, FSM states, flag bit positions and the
// multi-cycle opsel window (16..23 map onto their single-step base op at +8).
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StIter,
    StResp
  } alu_seq_state_e;

  // Flag bit positions within a 4-bit flag vector
  localparam int unsigned FlagZf = 3;
  localparam int unsigned FlagNf = 2;
  localparam int unsigned FlagCf = 1;
  localparam int unsigned FlagOf = 0;

  // Opsel codes of the shared ALU
  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_AND     = 5'd2;
  localparam logic [4:0] ALU_OR      = 5'd3;
  localparam logic [4:0] ALU_XOR     = 5'd4;
  localparam logic [4:0] ALU_SHORT_A = 5'd6;
  localparam logic [4:0] ALU_SHORT_B = 5'd7;
  localparam logic [4:0] ALU_LSL_M   = 5'd16;
  localparam logic [4:0] ALU_RSL_M   = 5'd17;
  localparam logic [4:0] ALU_ASR_M   = 5'd18;
  localparam logic [4:0] ALU_LSL     = 5'd24;
  localparam logic [4:0] ALU_RSL     = 5'd25;
  localparam logic [4:0] ALU_ASR     = 5'd26;

  localparam logic [4:0] MultiLo     = 5'd16;
  localparam logic [4:0] MultiHi     = 5'd23;
  localparam logic [4:0] MultiOffset = 5'd8;

  function automatic logic is_multi(input logic [4:0] op);
    return (op >= MultiLo) && (op <= MultiHi);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequencer that drives an external shared ALU, single-step or iterated by one per cycle.
// Define ALU_SEQ_ABORT_EN to add the abort input that cancels an operation in EXEC/ITER.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ALU_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_res,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  flags_q,
  output logic [15:0] alu_srcA,
  output logic [15:0] alu_srcB,
  output logic [4:0]  alu_opsel,
  output logic [3:0]  alu_flags,
  input  logic [15:0] alu_res,
  input  logic [3:0]  alu_flag_next,
  input  logic        alu_ready
);

  alu_seq_state_e   state_q;
  logic [4:0]       op_q;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      work_q;
  logic [3:0]       wflags_q;
  logic             abort_w;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Gated by rst so no request looks accepted while reset is held
  assign req_ready = rst && (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      work_q    <= '0;
      wflags_q  <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
      flags_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            cnt_q   <= req_b[CNT_W-1:0];
            state_q <= StExec;
          end
        end
        StExec: begin
          if (abort_w) begin
            state_q <= StIdle;
          end else if (is_multi(op_q)) begin
            if (cnt_q == '0) begin
              // Zero count: the operand passes through untouched, flags unchanged
              rsp_res   <= a_q;
              rsp_flags <= flags_q;
              state_q   <= StResp;
            end else begin
              work_q   <= a_q;
              wflags_q <= flags_q;
              state_q  <= StIter;
            end
          end else if (alu_ready) begin
            rsp_res   <= alu_res;
            rsp_flags <= alu_flag_next;
            flags_q   <= alu_flag_next;
            state_q   <= StResp;
          end
        end
        StIter: begin
          if (abort_w) begin
            state_q <= StIdle;
          end else if (alu_ready) begin
            work_q   <= alu_res;
            wflags_q <= alu_flag_next;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              rsp_res   <= alu_res;
              rsp_flags <= alu_flag_next;
              flags_q   <= alu_flag_next;
              state_q   <= StResp;
            end
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    alu_opsel = ALU_SHORT_B;
    alu_srcA  = '0;
    alu_srcB  = '0;
    alu_flags = '0;
    unique case (state_q)
      StExec: begin
        if (!is_multi(op_q)) begin
          alu_opsel = op_q;
          alu_srcA  = a_q;
          alu_srcB  = b_q;
          alu_flags = flags_q;
        end
      end
      StIter: begin
        alu_opsel = op_q + MultiOffset;
        alu_srcA  = work_q;
        alu_srcB  = 16'd1;
        alu_flags = wflags_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU, directed corner cases and randomized ops
// against a reference model. Covers the abort input when ALU_SEQ_ABORT_EN is defined.
module tb_alu_seq;

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpXor    = 5'd4;
  localparam logic [4:0] OpShortB = 5'd7;
  localparam logic [4:0] OpLslM   = 5'd16;
  localparam logic [4:0] OpRslM   = 5'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic [3:0]  flags_q;
  logic [15:0] alu_srcA;
  logic [15:0] alu_srcB;
  logic [4:0]  alu_opsel;
  logic [3:0]  alu_flags;
  logic [15:0] alu_res;
  logic [3:0]  alu_flag_next;
  logic        alu_ready = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] model_flags = 4'h0;

  always #5 clk = ~clk;

  alu_seq #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_flags    (rsp_flags),
    .flags_q      (flags_q),
    .alu_srcA     (alu_srcA),
    .alu_srcB     (alu_srcB),
    .alu_opsel    (alu_opsel),
    .alu_flags    (alu_flags),
    .alu_res      (alu_res),
    .alu_flag_next(alu_flag_next),
    .alu_ready    (alu_ready)
  );

  // Behavioural ALU; returns {ZF,NF,CF,OF,res}. CF/OF pass through where an op leaves them.
  function automatic logic [19:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] fin);
    logic [16:0] t;
    logic [15:0] r;
    logic cf, of;
    int sh;
    cf = fin[1];
    of = fin[0];
    sh = int'(b[3:0]);
    r  = '0;
    t  = '0;
    case (op)
      5'd0: begin
        t = {1'b0, a} + {1'b0, b}; r = t[15:0]; cf = t[16];
        of = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'd1: begin
        t = {1'b0, a} - {1'b0, b}; r = t[15:0]; cf = t[16];
        of = (a[15] != b[15]) && (r[15] != a[15]);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd6: r = a;
      5'd7: r = b;
      5'd24: begin t = {1'b0, a} << sh; r = t[15:0]; cf = t[16]; end
      5'd25: begin t = {a, 1'b0} >> sh; r = t[16:1]; cf = t[0]; end
      5'd26: begin t = $signed({a, 1'b0}) >>> sh; r = t[16:1]; cf = t[0]; end
      default: r = a + ~b;
    endcase
    return {(r == 16'h0), r[15], cf, of, r};
  endfunction

  assign {alu_flag_next, alu_res} = alu_fn(alu_opsel, alu_srcA, alu_srcB, alu_flags);

  // Reference: ops 16..23 apply base op (op+8) with operand 1, b[3:0] times
  function automatic logic [19:0] ref_op(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] f);
    logic [15:0] v;
    logic [3:0]  ff;
    logic [4:0]  bop;
    if (op >= 5'd16 && op <= 5'd23) begin
      v = a;
      ff = f;
      bop = op + 5'd8;
      for (int i = 0; i < int'(b[3:0]); i++) {ff, v} = alu_fn(bop, v, 16'd1, ff);
      return {ff, v};
    end
    return alu_fn(op, a, b, f);
  endfunction

  // Expected accept-to-rsp_valid latency when alu_ready is low for the first `stall` cycles
  function automatic int ref_lat(input logic [4:0] op, input logic [15:0] b, input int stall);
    int first;
    if (op >= 5'd16 && op <= 5'd23) begin
      if (b[3:0] == 4'd0) return 2;
      first = (stall + 1 > 2) ? stall + 1 : 2;
      return first + int'(b[3:0]);
    end
    return stall + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input int hold, input bit hold_req,
                        output logic [15:0] res, output logic [3:0] flg, output logic [3:0] fq,
                        output int lat, output int alu_cyc, output int alu_busy,
                        output bit srcb_one, output bit hold_ok, output bit timeout);
    int guard;
    timeout = 0; srcb_one = 1; hold_ok = 1; alu_cyc = 0; alu_busy = 0; lat = 0;
    res = '0; flg = '0; fq = '0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    alu_ready = 1'b0; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin tick(); guard++; end
    if (!req_ready) begin timeout = 1; req_valid = 1'b0; return; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      alu_ready = (lat > stall);
      #1;
      if (alu_opsel != OpShortB) begin
        alu_busy++;
        if (alu_ready) begin
          alu_cyc++;
          if (alu_srcB != 16'd1) srcb_one = 0;
        end
      end
      tick();
      lat++;
    end
    alu_ready = 1'b0;
    if (!rsp_valid) begin timeout = 1; return; end
    res = rsp_res; flg = rsp_flags; fq = flags_q;
    for (int i = 0; i < hold; i++) begin
      if (hold_req) begin
        req_valid = 1'b1; req_op = OpXor; req_a = 16'hF0F0; req_b = 16'h0FF0;
      end
      tick();
      if (rsp_res !== res || rsp_flags !== flg || rsp_valid !== 1'b1 || req_ready !== 1'b0)
        hold_ok = 0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (hold > 0 && (rsp_valid !== 1'b0 || req_ready !== 1'b1)) hold_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_tests++; if (rsp_res !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_res got %h want 0", rsp_res); end
    n_tests++; if (rsp_flags !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_flags got %h want 0", rsp_flags); end
    n_tests++; if (flags_q !== 4'h0) begin n_fail++; $display("FAIL reset_flags_q got %h want 0", flags_q); end
    n_tests++;
    if (alu_opsel !== OpShortB || alu_srcA !== 16'h0 || alu_srcB !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_alu_idle got op=%h a=%h b=%h want op=%h a=0 b=0",
               alu_opsel, alu_srcA, alu_srcB, OpShortB);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
    model_flags = 4'h0;
  endtask

  task automatic test_add();
    logic [15:0] res; logic [3:0] flg, fq; int lat, cyc, busy; bit s1, hok, to;
    run_op(OpAdd, 16'h7FFF, 16'h0001, 0, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL add_timeout got timeout want completion"); end
    n_tests++; if (res !== 16'h8000) begin n_fail++; $display("FAIL add_res got %h want 8000", res); end
    n_tests++; if (flg !== 4'b0101) begin n_fail++; $display("FAIL add_flags got %b want 0101", flg); end
    n_tests++; if (fq !== 4'b0101) begin n_fail++; $display("FAIL add_flags_q got %b want 0101", fq); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", lat); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL add_alu_cycles got %0d want 1", cyc); end
    model_flags = 4'b0101;
  endtask

  task automatic test_multi();
    logic [15:0] res; logic [3:0] flg, fq; int lat, cyc, busy; bit s1, hok, to;
    logic [19:0] exp;
    exp = ref_op(OpRslM, 16'h8000, 16'd3, model_flags);
    run_op(OpRslM, 16'h8000, 16'd3, 0, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rslm_timeout got timeout want completion"); end
    n_tests++; if (res !== 16'h1000) begin n_fail++; $display("FAIL rslm_res got %h want 1000", res); end
    n_tests++; if (flg !== exp[19:16]) begin n_fail++; $display("FAIL rslm_flags got %b want %b", flg, exp[19:16]); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL rslm_latency got %0d want 5", lat); end
    n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL rslm_alu_cycles got %0d want 3", cyc); end
    n_tests++; if (s1 !== 1'b1) begin n_fail++; $display("FAIL rslm_srcb got non-1 srcB want 1"); end
    model_flags = exp[19:16];
    // Largest count: 1 shifted left 15 times
    exp = ref_op(OpLslM, 16'h0001, 16'h000F, model_flags);
    run_op(OpLslM, 16'h0001, 16'h000F, 0, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (res !== 16'h8000) begin n_fail++; $display("FAIL lslm_max_res got %h want 8000", res); end
    n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL lslm_max_latency got %0d want 17", lat); end
    n_tests++; if (fq !== exp[19:16]) begin n_fail++; $display("FAIL lslm_max_flags_q got %b want %b", fq, exp[19:16]); end
    model_flags = exp[19:16];
  endtask

  task automatic test_count_zero();
    logic [15:0] res; logic [3:0] flg, fq; int lat, cyc, busy; bit s1, hok, to;
    run_op(OpRslM, 16'h1234, 16'h0010, 0, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (res !== 16'h1234) begin n_fail++; $display("FAIL cnt0_res got %h want 1234", res); end
    n_tests++; if (flg !== model_flags) begin n_fail++; $display("FAIL cnt0_flags got %b want %b", flg, model_flags); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL cnt0_latency got %0d want 2", lat); end
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL cnt0_alu_busy got %0d cycles want 0", busy); end
  endtask

  task automatic test_stall();
    logic [15:0] res; logic [3:0] flg, fq; int lat, cyc, busy; bit s1, hok, to;
    logic [19:0] exp;
    exp = ref_op(OpAdd, 16'h00FF, 16'h0F01, model_flags);
    run_op(OpAdd, 16'h00FF, 16'h0F01, 2, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL stall_latency got %0d want 4", lat); end
    n_tests++; if (res !== exp[15:0]) begin n_fail++; $display("FAIL stall_res got %h want %h", res, exp[15:0]); end
    model_flags = exp[19:16];
  endtask

  task automatic test_back_to_back();
    logic [15:0] res; logic [3:0] flg, fq; int lat, cyc, busy; bit s1, hok, to;
    logic [19:0] exp;
    exp = ref_op(OpAdd, 16'h0001, 16'h0002, model_flags);
    run_op(OpAdd, 16'h0001, 16'h0002, 0, 4, 1, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (hok !== 1'b1) begin n_fail++; $display("FAIL hold_stable got unstable/accepting want held"); end
    n_tests++; if (res !== 16'h0003) begin n_fail++; $display("FAIL hold_res got %h want 0003", res); end
    model_flags = exp[19:16];
    exp = ref_op(OpXor, 16'hF0F0, 16'h0FF0, model_flags);
    run_op(OpXor, 16'hF0F0, 16'h0FF0, 0, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
    n_tests++; if (res !== 16'hFF00 || lat !== 2) begin
      n_fail++; $display("FAIL second_op got res=%h lat=%0d want FF00 lat=2", res, lat);
    end
    model_flags = exp[19:16];
  endtask

  task automatic test_random();
    logic [15:0] res, a, b; logic [3:0] flg, fq; int lat, cyc, busy, stall; bit s1, hok, to;
    logic [19:0] exp;
    logic [4:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      a = 16'($urandom);
      b = 16'($urandom);
      stall = $urandom_range(0, 3);
      exp = ref_op(op, a, b, model_flags);
      run_op(op, a, b, stall, 0, 0, res, flg, fq, lat, cyc, busy, s1, hok, to);
      n_tests++;
      if (to || res !== exp[15:0] || flg !== exp[19:16] || fq !== exp[19:16] ||
          lat !== ref_lat(op, b, stall)) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got res=%h fl=%b fq=%b lat=%0d want res=%h fl=%b lat=%0d",
                 i, op, a, b, res, flg, fq, lat, exp[15:0], exp[19:16], ref_lat(op, b, stall));
      end
      model_flags = exp[19:16];
    end
  endtask

`ifdef ALU_SEQ_ABORT_EN
  task automatic test_abort();
    int seen;
    req_valid = 1'b1; req_op = OpRslM; req_a = 16'hABCD; req_b = 16'd5;
    alu_ready = 1'b1;
    tick();                  // accepted, EXEC
    req_valid = 1'b0;
    tick(); tick();          // 2nd ITER cycle
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || flags_q !== model_flags) begin
      n_fail++;
      $display("FAIL abort_iter got rv=%b rr=%b fq=%b want rv=0 rr=1 fq=%b",
               rsp_valid, req_ready, flags_q, model_flags);
    end
    // Abort wins over a completing ADD in EXEC
    req_valid = 1'b1; req_op = OpAdd; req_a = 16'h0001; req_b = 16'h0001;
    tick();
    req_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin if (rsp_valid) seen++; tick(); end
    n_tests++;
    if (seen !== 0 || flags_q !== model_flags) begin
      n_fail++; $display("FAIL abort_exec got rsp cycles=%0d fq=%b want 0 fq=%b", seen, flags_q, model_flags);
    end
    alu_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_midop();
    int seen;
    req_valid = 1'b1; req_op = OpRslM; req_a = 16'hABCD; req_b = 16'd5;
    alu_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();          // 2nd ITER cycle
    rst = 1'b0;
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_res !== 16'h0 || rsp_flags !== 4'h0 || flags_q !== 4'h0 ||
        req_ready !== 1'b0 || alu_opsel !== OpShortB || alu_srcA !== 16'h0) begin
      n_fail++;
      $display("FAIL midop_reset got rv=%b res=%h fl=%b fq=%b rr=%b op=%h want all idle/zero",
               rsp_valid, rsp_res, rsp_flags, flags_q, req_ready, alu_opsel);
    end
    rst = 1'b1;
    model_flags = 4'h0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin if (rsp_valid) seen++; tick(); end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midop_no_rsp got %0d rsp cycles want 0", seen); end
    alu_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_multi();
    test_count_zero();
    test_stall();
    test_back_to_back();
    test_random();
`ifdef ALU_SEQ_ABORT_EN
    test_abort();
`endif
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
